branch_predictor_btb: RTL and testbench

BRANCH_PREDICTOR_BTB -- requirements
Module: branch_predictor_btb

---
 rtl/branch_predictor_btb_if.sv | 31 +++
 rtl/branch_predictor_btb.sv | 85 ++++++++
 tb/tb_branch_predictor_btb.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_btb_if.sv
// branch_predictor_btb_if: lookup, update and status signals of the branch target buffer
interface branch_predictor_btb_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              lk_pc_valid_unused;
    logic [ADDR_W-1:0] lk_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_pred_taken;
    logic [ADDR_W-1:0] upd_pred_target;
    logic              flush;
    logic              mispredict;
    logic [CNT_W-1:0]  mispredict_cnt;

    modport master (
        output lk_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, flush,
        input  pred_taken, pred_target, mispredict, mispredict_cnt
    );

    modport slave (
        input  lk_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, flush,
        output pred_taken, pred_target, mispredict, mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped BTB with 2-bit counters and a saturating mispredict counter
module branch_predictor_btb #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    branch_predictor_btb_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [1:0]         r_cnt    [ENTRIES];
    logic               r_mis;
    logic [CNT_W-1:0]   r_mis_cnt;

    logic [IDX_W-1:0] w_lk_idx;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_lk_hit;
    logic             w_up_hit;
    logic             w_mis;
    logic [1:0]       w_cnt_nxt;
    logic             w_unused;

    assign w_lk_idx = bus.lk_pc[IDX_W+1:2];
    assign w_lk_tag = bus.lk_pc[ADDR_W-1:IDX_W+2];
    assign w_up_idx = bus.upd_pc[IDX_W+1:2];
    assign w_up_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];
    assign w_unused = ^{bus.lk_pc[1:0], bus.upd_pc[1:0]};

    // Lookup reads registered state only, so a same-cycle update is never bypassed
    always_comb begin
        w_lk_hit        = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
        bus.pred_taken  = w_lk_hit && r_cnt[w_lk_idx][1];
        bus.pred_target = bus.pred_taken ? r_target[w_lk_idx] : '0;
    end

    // Update-side hit, counter step and mispredict condition
    always_comb begin
        w_up_hit  = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
        w_cnt_nxt = bus.upd_taken ? ((r_cnt[w_up_idx] == 2'd3) ? 2'd3 : r_cnt[w_up_idx] + 2'd1)
                                  : ((r_cnt[w_up_idx] == 2'd0) ? 2'd0 : r_cnt[w_up_idx] - 2'd1);
        w_mis     = bus.upd_valid && ((bus.upd_pred_taken != bus.upd_taken) ||
                    (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
    end

    // Table maintenance and mispredict accounting; flush overrides the update but not the accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= '0;
            r_tag     <= '{default: '0};
            r_target  <= '{default: '0};
            r_cnt     <= '{default: '0};
            r_mis     <= 1'b0;
            r_mis_cnt <= '0;
        end else begin
            r_mis <= w_mis;
            if (w_mis && (r_mis_cnt != '1))
                r_mis_cnt <= r_mis_cnt + 1'b1;
            if (bus.flush) begin
                r_valid <= '0;
            end else if (bus.upd_valid) begin
                if (w_up_hit) begin
                    r_cnt[w_up_idx] <= w_cnt_nxt;
                    if (bus.upd_taken)
                        r_target[w_up_idx] <= bus.upd_target;
                end else if (bus.upd_taken) begin
                    r_valid[w_up_idx]  <= 1'b1;
                    r_tag[w_up_idx]    <= w_up_tag;
                    r_target[w_up_idx] <= bus.upd_target;
                    r_cnt[w_up_idx]    <= 2'd2;
                end
            end
        end
    end

    assign bus.mispredict     = r_mis;
    assign bus.mispredict_cnt = r_mis_cnt;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb_branch_predictor_btb: directed checks of allocation, hysteresis, aliasing, flush, saturation and reset
module tb_branch_predictor_btb;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    branch_predictor_btb_if #(.ADDR_W(32), .CNT_W(16)) bus ();
    branch_predictor_btb_if #(.ADDR_W(32), .CNT_W(2))  bus2 ();

    branch_predictor_btb #(.ADDR_W(32), .ENTRIES(16), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    branch_predictor_btb #(.ADDR_W(32), .ENTRIES(16), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt, input logic fl);
        bus.upd_valid       = 1'b1;
        bus.upd_pc          = pc;
        bus.upd_taken       = tk;
        bus.upd_target      = tgt;
        bus.upd_pred_taken  = ptk;
        bus.upd_pred_target = ptgt;
        bus.flush           = fl;
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        bus.lk_pc = pc;
        #1;
        chk({tag, "_taken"}, 64'(bus.pred_taken), 64'(tk));
        chk({tag, "_target"}, 64'(bus.pred_target), 64'(tgt));
    endtask

    task automatic mis(input string tag, input logic m, input int cnt);
        chk({tag, "_mis"}, 64'(bus.mispredict), 64'(m));
        chk({tag, "_cnt"}, 64'(bus.mispredict_cnt), 64'(cnt));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        {bus.lk_pc, bus.upd_valid, bus.upd_pc, bus.upd_taken, bus.upd_target,
         bus.upd_pred_taken, bus.upd_pred_target, bus.flush} = '0;
        {bus2.lk_pc, bus2.upd_valid, bus2.upd_pc, bus2.upd_taken, bus2.upd_target,
         bus2.upd_pred_taken, bus2.upd_pred_target, bus2.flush} = '0;
        #1 rst_n = 1'b0;
        #1;
        look("rst", 32'h40, 1'b0, 32'h0);
        mis("rst", 1'b0, 0);
        chk("rst_cnt2", 64'(bus2.mispredict_cnt), 64'd0);
        #9 rst_n = 1'b1;

        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        mis("alloc", 1'b1, 1);
        look("alloc", 32'h40, 1'b1, 32'h100);

        upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        mis("nt1", 1'b1, 2);
        look("nt1", 32'h40, 1'b0, 32'h0);
        upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        mis("nt2", 1'b0, 2);
        look("nt2", 32'h40, 1'b0, 32'h0);
        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        mis("tk1", 1'b1, 3);
        look("tk1", 32'h40, 1'b0, 32'h0);
        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        mis("tk2", 1'b1, 4);
        look("tk2", 32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0);
        mis("tk3", 1'b0, 4);
        upd(32'h40, 1'b1, 32'h200, 1'b1, 32'h100, 1'b0);
        mis("tgt", 1'b1, 5);
        look("tgt", 32'h40, 1'b1, 32'h200);
        upd(32'h40, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
        look("sat3", 32'h40, 1'b1, 32'h200);
        upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        mis("dec", 1'b0, 5);
        look("dec", 32'h40, 1'b1, 32'h200);

        upd(32'h440, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
        mis("alias", 1'b1, 6);
        look("alias_old", 32'h40, 1'b0, 32'h0);
        look("alias_new", 32'h440, 1'b1, 32'h300);
        look("lowbits", 32'h443, 1'b1, 32'h300);
        upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        look("miss_nt", 32'h440, 1'b1, 32'h300);
        look("miss_nt_old", 32'h40, 1'b0, 32'h0);

        upd(32'hC0, 1'b1, 32'h500, 1'b1, 32'h500, 1'b0);
        mis("allocC0", 1'b0, 6);
        look("allocC0", 32'hC0, 1'b1, 32'h500);
        upd(32'h80, 1'b1, 32'h600, 1'b0, 32'h0, 1'b1);
        mis("flush", 1'b1, 7);
        look("flush80", 32'h80, 1'b0, 32'h0);
        look("flushC0", 32'hC0, 1'b0, 32'h0);
        look("flush440", 32'h440, 1'b0, 32'h0);
        upd(32'h80, 1'b1, 32'h600, 1'b1, 32'h600, 1'b1);
        mis("flush_ok", 1'b0, 7);
        look("flush_ok80", 32'h80, 1'b0, 32'h0);

        bus2.upd_valid  = 1'b1;
        bus2.upd_pc     = 32'h40;
        bus2.upd_taken  = 1'b1;
        bus2.upd_target = 32'h100;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d", i), 64'(bus2.mispredict_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
        end
        bus2.upd_valid = 1'b0;

        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        mis("realloc", 1'b1, 8);
        look("realloc", 32'h40, 1'b1, 32'h100);
        #2 rst_n = 1'b0;
        #1;
        look("async", 32'h40, 1'b0, 32'h0);
        mis("async", 1'b0, 0);
        chk("async_cnt2", 64'(bus2.mispredict_cnt), 64'd0);
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = 32'hC0;
        bus.upd_taken      = 1'b1;
        bus.upd_target     = 32'h700;
        bus.upd_pred_taken = 1'b0;
        @(posedge clk);
        #2;
        bus.upd_valid = 1'b0;
        rst_n         = 1'b1;
        @(posedge clk);
        #1;
        mis("post_rst", 1'b0, 0);
        look("post40", 32'h40, 1'b0, 32'h0);
        look("postC0", 32'hC0, 1'b0, 32'h0);
        look("post440", 32'h440, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
